peripheral_wb_master_burst_engine: RTL and testbench
====================================================

// Module: peripheral_wb_master_burst_engine
// PURPOSE
//  Synthesizable, parametrised Wishbone B3 master. Turns a command plus write-data stream into classic, constant or
//  incrementing (linear/wrap4/8/16) bus cycles. Returns read data and per-command status on streams.
//  Sits between a DMA/bridge front end and the peripheral Wishbone interconnect; also reused as the bench stimulus master.
// PARAMETERS
//  AW               32  address width
//  DW               32  data width, multiple of 8; ADR_LSB = $clog2(DW/8)
//  MAX_BURST_LEN    32  maximum beats per command; LEN_W = $clog2(MAX_BURST_LEN)+1
//  MAX_WAIT_STATES   8  upper bound of programmable inter-cycle gap; WS_W = $clog2(MAX_WAIT_STATES)+1
//  TIMEOUT_CYC     256  ack watchdog limit (only with WB_MASTER_TIMEOUT_EN)
// PORTS
//  wb_clk_i      in   1      clock
//  wb_rst_ni     in   1      asynchronous active-low reset
//  cfg_wait_i    in   WS_W   idle cycles inserted after each bus cycle, saturated at MAX_WAIT_STATES
//  cmd_valid_i   in   1      command valid
//  cmd_ready_o   out  1      command accepted when valid&ready
//  cmd_adr_i     in   AW     start byte address
//  cmd_we_i      in   1      1=write, 0=read
//  cmd_sel_i     in   DW/8   byte select, held for every beat
//  cmd_cti_i     in   3      CTI_CLASSIC / CTI_CONST_BURST / CTI_INC_BURST
//  cmd_bte_i     in   2      burst type for incrementing bursts
//  cmd_len_i     in   LEN_W  beat count 1..MAX_BURST_LEN; 0 treated as 1; >MAX clipped to MAX
//  wdat_valid_i  in   1      write beat valid
//  wdat_ready_o  out  1      write beat consumed (== stb & ack & we)
//  wdat_i        in   DW     write beat data
//  rdat_valid_o  out  1      read beat valid, one cycle per beat
//  rdat_ready_i  in   1      read sink can take a beat this cycle
//  rdat_o        out  DW     read data (registered wb_dat_i)
//  rdat_last_o   out  1      final beat of command
//  rsp_valid_o   out  1      one-cycle status pulse per command
//  rsp_err_o     out  1      cycle ended by wb_err_i (or timeout)
//  rsp_rty_o     out  1      cycle ended by wb_rty_i
//  rsp_beats_o   out  LEN_W  beats acked before termination
//  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0]   out   Wishbone master
//  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i                                                    in    Wishbone slave response
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; cmd_ready_o=0 during reset, 1 first cycle after release.
//  - FSM: IDLE -> BUS on cmd accept; BUS -> GAP on last ack, err or rty; GAP -> IDLE after cfg_wait_i cycles
//    (GAP skipped when 0). rsp_valid_o pulses on the BUS exit cycle. cmd_ready_o=1 only in IDLE.
//  - Latency: command accepted at edge N -> wb_cyc_o=1 from cycle N+1. Min command-to-command = len + 1 + cfg_wait_i.
//  - stb gating: wb_stb_o=1 in BUS only if (we & wdat_valid_i) | (!we & rdat_ready_i); otherwise stb=0, cyc held,
//    adr/cti unchanged (legal B3 wait).
//  - Beat completes on stb&ack: adr advances per wb_next_adr; rdat_valid_o=1 the next cycle for reads; beat counter++.
//  - CTI: classic -> 000 for all beats; bursts -> cmd_cti_i until last beat, 111 on last beat; len=1 burst emits 111 only.
//    bte = cmd_bte_i for incrementing, 00 otherwise.
//  - Address: linear wraps modulo 2^AW; wrapN wraps within an aligned N*DW/8 block; constant never changes.
//  - err/rty: sampled only with stb; dominate same-cycle ack (priority err > rty > ack); burst aborted, cyc/stb drop next
//    cycle. Remaining write beats are not consumed; no rdat beat for the failing transfer.
//  - Reset mid-burst: cyc/stb/outputs 0 asynchronously; no rsp pulse; in-flight command discarded.
// CONFIGURATION
//  WB_MASTER_TIMEOUT_EN: defined -> counter of cycles with stb=1 and no ack/err/rty; at TIMEOUT_CYC abort as err.
//    Reports rsp_err_o=1 and rsp_beats_o = beats done. Undefined -> no counter; master waits indefinitely for a response.
// STRUCTURE
//  - peripheral_wb_pkg: CTI_*/BTE_* constants, wb_next_adr(), typedef enum {IDLE,BUS,GAP} wbm_state_t,
//    struct wbm_cmd_t (adr, we, sel, cti, bte, len).
//  - Sub-module peripheral_wb_master_adr_gen: registered next-address/last-beat generator (load, advance, beat count).
// TESTING
//  1 classic write adr=0x100 dat=0xDEADBEEF sel=0xF, cfg_wait_i=2 -> one cycle cti=000, rsp_beats=1,
//    cmd_ready back 3 cycles after ack.
//  2 incr linear write len=4 adr=0x00, then read -> cti 010,010,010,111; adr 0,4,8,C; rdat matches, last on 4th.
//  3 wrap4 read adr=0x18 len=4 -> adr 18,1C,10,14; bte=01.
//  4 write len=8, wdat_valid_i low for 3 cycles after beat 2 -> stb=0 those cycles, cyc=1, adr held; 8 beats total.
//  5 slave err on beat 3 of len 8 -> cyc=0 next cycle, rsp_err=1, rsp_beats=2; wb_rty_i on beat 1 -> rsp_rty=1, rsp_beats=0.
//  6 wb_rst_ni low mid-burst -> all bus outputs 0 same cycle, no rsp; with WB_MASTER_TIMEOUT_EN and no ack
//    -> err after 256 cycles.

Source files
------------

// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 constants, master FSM state, command record and the burst address-step function.
package peripheral_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC     = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST = 3'b001;
    localparam logic [2:0] CTI_INC_BURST   = 3'b010;
    localparam logic [2:0] CTI_END_BURST   = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } wbm_state_t;

    // Fields are sized for the widest supported bus; instances use the low bits.
    typedef struct packed {
        logic [63:0] adr;
        logic        we;
        logic [15:0] sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [15:0] len;
    } wbm_cmd_t;

    // Address of the following beat. Classic multi-beat commands step linearly like an
    // incrementing burst; constant bursts never move.
    function automatic logic [63:0] wb_next_adr(
        input logic [63:0] adr,
        input logic [2:0]  cti,
        input logic [1:0]  bte,
        input int unsigned adr_lsb
    );
        logic [63:0] step;
        logic [63:0] mask;
        step = 64'd1 << adr_lsb;
        case (bte)
            BTE_WRAP4:  mask = (step << 2) - 64'd1;
            BTE_WRAP8:  mask = (step << 3) - 64'd1;
            BTE_WRAP16: mask = (step << 4) - 64'd1;
            default:    mask = '1;
        endcase
        if (cti == CTI_CONST_BURST)
            return adr;
        if (cti != CTI_INC_BURST || bte == BTE_LINEAR)
            return adr + step;
        return (adr & ~mask) | ((adr + step) & mask);
    endfunction

endpackage

// File: rtl/peripheral_wb_master_adr_gen.sv
// Registered beat address, completed-beat count and last-beat flag for one command.
module peripheral_wb_master_adr_gen
    import peripheral_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int LEN_W   = 6,
    parameter int ADR_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AW-1:0]    load_adr,
    input  logic [LEN_W-1:0] load_len,
    input  logic             advance,
    input  logic [2:0]       cti,
    input  logic [1:0]       bte,
    output logic [AW-1:0]    adr,
    output logic [LEN_W-1:0] beats,
    output logic             last
);

    logic [AW-1:0]    adr_reg;
    logic [LEN_W-1:0] beats_reg;
    logic [LEN_W-1:0] len_reg;
    logic             last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_reg   <= '0;
            beats_reg <= '0;
            len_reg   <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            adr_reg   <= load_adr;
            beats_reg <= '0;
            len_reg   <= load_len;
            last_reg  <= (load_len == LEN_W'(1));
        end else if (advance) begin
            adr_reg   <= AW'(wb_next_adr(64'(adr_reg), cti, bte, ADR_LSB));
            beats_reg <= beats_reg + LEN_W'(1);
            // The beat after this one is the last when two more completions reach len.
            last_reg  <= ((beats_reg + LEN_W'(2)) == len_reg);
        end
    end

    assign adr   = adr_reg;
    assign beats = beats_reg;
    assign last  = last_reg;

endmodule

// File: rtl/peripheral_wb_master_burst_engine.sv
// Wishbone B3 burst master: command + write stream in, bus cycles out, read and status streams back.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module peripheral_wb_master_burst_engine
    import peripheral_wb_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_BURST_LEN   = 32,
    parameter int MAX_WAIT_STATES = 8,
    parameter int TIMEOUT_CYC     = 256,
    localparam int SW      = DW / 8,
    localparam int ADR_LSB = $clog2(SW),
    localparam int LEN_W   = $clog2(MAX_BURST_LEN) + 1,
    localparam int WS_W    = $clog2(MAX_WAIT_STATES) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [WS_W-1:0]  cfg_wait_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [AW-1:0]    cmd_adr_i,
    input  logic             cmd_we_i,
    input  logic [SW-1:0]    cmd_sel_i,
    input  logic [2:0]       cmd_cti_i,
    input  logic [1:0]       cmd_bte_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wdat_valid_i,
    output logic             wdat_ready_o,
    input  logic [DW-1:0]    wdat_i,
    output logic             rdat_valid_o,
    input  logic             rdat_ready_i,
    output logic [DW-1:0]    rdat_o,
    output logic             rdat_last_o,
    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic             rsp_rty_o,
    output logic [LEN_W-1:0] rsp_beats_o,
    output logic [AW-1:0]    wb_adr_o,
    output logic [DW-1:0]    wb_dat_o,
    output logic [SW-1:0]    wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i
);

    wbm_state_t       state_reg, state_next;
    wbm_cmd_t         cmd_reg;
    logic [WS_W-1:0]  gap_reg, gap_next;
    logic             ready_reg;
    logic [DW-1:0]    rdat_reg;
    logic             rdat_valid_reg;
    logic             rdat_last_reg;

    logic [LEN_W-1:0] len_clip;
    logic [WS_W-1:0]  wait_sat;
    logic [2:0]       cti_norm;
    logic             cmd_fire;
    logic             in_bus;
    logic             is_burst;
    logic             stb;
    logic             ack_ok;
    logic             err_hit;
    logic             rty_hit;
    logic             finish;
    logic             timeout_hit;
    logic [AW-1:0]    cur_adr;
    logic [LEN_W-1:0] beats;
    logic             last;
    logic             unused_cmd_bits;

    always_comb begin
        len_clip = cmd_len_i;
        if (cmd_len_i == '0)
            len_clip = LEN_W'(1);
        else if (cmd_len_i > LEN_W'(MAX_BURST_LEN))
            len_clip = LEN_W'(MAX_BURST_LEN);
    end

    assign wait_sat = (cfg_wait_i > WS_W'(MAX_WAIT_STATES)) ? WS_W'(MAX_WAIT_STATES) : cfg_wait_i;
    // Unknown cycle types are issued as classic cycles.
    assign cti_norm = (cmd_cti_i == CTI_CONST_BURST || cmd_cti_i == CTI_INC_BURST) ? cmd_cti_i : CTI_CLASSIC;

    assign cmd_fire = cmd_valid_i & ready_reg;
    assign in_bus   = (state_reg == BUS);
    assign is_burst = (cmd_reg.cti != CTI_CLASSIC);

    // Strobe only when the data side can complete the beat; otherwise cyc holds as a B3 wait.
    assign stb     = in_bus & (cmd_reg.we ? wdat_valid_i : rdat_ready_i);
    assign err_hit = stb & (wb_err_i | timeout_hit);
    assign rty_hit = stb & ~err_hit & wb_rty_i;
    assign ack_ok  = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i & ~timeout_hit;
    assign finish  = err_hit | rty_hit | (ack_ok & last);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt_reg;
    logic            stall_cyc;

    assign stall_cyc   = stb & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
    assign timeout_hit = stall_cyc & (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            to_cnt_reg <= '0;
        else if (!in_bus || (stb && !stall_cyc) || timeout_hit)
            to_cnt_reg <= '0;
        else if (stall_cyc)
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_fire)
                    state_next = BUS;
            end
            BUS: begin
                if (finish) begin
                    if (wait_sat == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        gap_next   = wait_sat - WS_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_reg == '0)
                    state_next = IDLE;
                else
                    gap_next = gap_reg - WS_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= IDLE;
            gap_reg        <= '0;
            ready_reg      <= 1'b0;
            cmd_reg        <= '0;
            rdat_reg       <= '0;
            rdat_valid_reg <= 1'b0;
            rdat_last_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gap_reg        <= gap_next;
            ready_reg      <= (state_next == IDLE);
            rdat_valid_reg <= ack_ok & ~cmd_reg.we;
            rdat_last_reg  <= ack_ok & ~cmd_reg.we & last;
            if (ack_ok && !cmd_reg.we)
                rdat_reg <= wb_dat_i;
            if (cmd_fire) begin
                cmd_reg.adr <= 64'(cmd_adr_i);
                cmd_reg.we  <= cmd_we_i;
                cmd_reg.sel <= 16'(cmd_sel_i);
                cmd_reg.cti <= cti_norm;
                cmd_reg.bte <= (cti_norm == CTI_INC_BURST) ? cmd_bte_i : BTE_LINEAR;
                cmd_reg.len <= 16'(len_clip);
            end
        end
    end

    peripheral_wb_master_adr_gen #(
        .AW      (AW),
        .LEN_W   (LEN_W),
        .ADR_LSB (ADR_LSB)
    ) u_adr_gen (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (cmd_fire),
        .load_adr (cmd_adr_i),
        .load_len (len_clip),
        .advance  (ack_ok),
        .cti      (cmd_reg.cti),
        .bte      (cmd_reg.bte),
        .adr      (cur_adr),
        .beats    (beats),
        .last     (last)
    );

    // The record keeps the full command; address and length live on in the generator.
    assign unused_cmd_bits = ^{cmd_reg.adr, cmd_reg.sel, cmd_reg.len};

    assign cmd_ready_o  = ready_reg;
    assign wb_cyc_o     = in_bus;
    assign wb_stb_o     = stb;
    assign wb_we_o      = in_bus & cmd_reg.we;
    assign wb_adr_o     = in_bus ? cur_adr : '0;
    assign wb_sel_o     = in_bus ? cmd_reg.sel[SW-1:0] : '0;
    assign wb_dat_o     = (in_bus && cmd_reg.we) ? wdat_i : '0;
    assign wb_cti_o     = !in_bus ? CTI_CLASSIC :
                          !is_burst ? CTI_CLASSIC :
                          last ? CTI_END_BURST : cmd_reg.cti;
    assign wb_bte_o     = in_bus ? cmd_reg.bte : BTE_LINEAR;
    assign wdat_ready_o = ack_ok & cmd_reg.we;

    assign rdat_valid_o = rdat_valid_reg;
    assign rdat_o       = rdat_reg;
    assign rdat_last_o  = rdat_last_reg;

    assign rsp_valid_o  = finish;
    assign rsp_err_o    = err_hit;
    assign rsp_rty_o    = rty_hit;
    assign rsp_beats_o  = finish ? (beats + LEN_W'(ack_ok)) : '0;

endmodule

// File: tb/tb_peripheral_wb_master_burst_engine.sv
// Directed and random commands against a command-level address/data model and a memory slave.
module tb_peripheral_wb_master_burst_engine;
    import peripheral_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_wait;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_cti;
    logic [1:0]  cmd_bte;
    logic [5:0]  cmd_len;
    logic        wdat_valid, wdat_ready, rdat_valid, rdat_ready, rdat_last;
    logic [31:0] wdat, rdat;
    logic        rsp_valid, rsp_err, rsp_rty;
    logic [5:0]  rsp_beats;
    logic [31:0] wb_adr, wb_dat_out, wb_dat_in;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;

    int tests = 0;
    int fails = 0;
    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];

    always #5 clk = ~clk;

    peripheral_wb_master_burst_engine dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_wait_i(cfg_wait),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr), .cmd_we_i(cmd_we),
        .cmd_sel_i(cmd_sel), .cmd_cti_i(cmd_cti), .cmd_bte_i(cmd_bte), .cmd_len_i(cmd_len),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat),
        .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_o(rdat), .rdat_last_o(rdat_last),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rty_o(rsp_rty), .rsp_beats_o(rsp_beats),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Address of beat i computed directly from the start address.
    function automatic logic [31:0] model_adr(input logic [31:0] base, input logic [2:0] cti,
                                              input logic [1:0] bte, input int i);
        logic [31:0] blk;
        if (cti == CTI_CONST_BURST) return base;
        if (cti != CTI_INC_BURST || bte == BTE_LINEAR) return base + 32'(i * 4);
        blk = (bte == BTE_WRAP4) ? 32'd16 : (bte == BTE_WRAP8) ? 32'd32 : 32'd64;
        return (base / blk) * blk + ((base % blk + 32'(i * 4)) % blk);
    endfunction

    task automatic issue(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [2:0] cti,
                         input logic [1:0] bte, input logic [5:0] len, input logic [3:0] wait_cfg);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_adr = adr; cmd_we = we; cmd_sel = sel;
        cmd_cti = cti; cmd_bte = bte; cmd_len = len; cfg_wait = wait_cfg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [2:0] cti,
                          input logic [1:0] bte, input int len, input int wait_cfg, input int err_beat,
                          input int rty_beat, input int stall_after, input logic [31:0] seed_dat);
        int n, k, stalls, gap, ws;
        bit done, beat_ok, term, exp_stb, is_burst;
        logic [31:0] eadr [$];
        logic [31:0] wd [$];
        logic [31:0] cur, rexp;
        logic [7:0]  idx;
        logic [2:0]  exp_cti;
        n = (len <= 0) ? 1 : ((len > 32) ? 32 : len);
        is_burst = (cti == CTI_CONST_BURST) || (cti == CTI_INC_BURST);
        for (int i = 0; i < n; i++) begin
            eadr.push_back(model_adr(adr, cti, bte, i));
            wd.push_back((seed_dat != 0) ? seed_dat + 32'(i) : $urandom);
        end
        issue(adr, we, sel, cti, bte, 6'(len), 4'(wait_cfg));
        k = 0; done = 0; stalls = 0; rexp = '0;
        for (int c = 0; c < 2000 && !done; c++) begin
            wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
            if (we) begin
                if (k == stall_after && stalls < 3) begin
                    wdat_valid = 1'b0;
                    stalls++;
                end else begin
                    wdat_valid = (stall_after >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                rdat_ready = ($urandom_range(0, 1) != 0);
            end else begin
                wdat_valid = ($urandom_range(0, 1) != 0);
                rdat_ready = ($urandom_range(0, 3) != 0);
            end
            wdat = wd[k];
            cur  = eadr[k];
            idx  = cur[9:2];
            #1;
            exp_stb = we ? wdat_valid : rdat_ready;
            exp_cti = !is_burst ? CTI_CLASSIC : (k == n - 1) ? CTI_END_BURST : cti;
            check("cyc", 64'(wb_cyc), 64'(1));
            check("stb", 64'(wb_stb), 64'(exp_stb));
            check("adr", 64'(wb_adr), 64'(cur));
            check("cti", 64'(wb_cti), 64'(exp_cti));
            check("bte", 64'(wb_bte), 64'((cti == CTI_INC_BURST) ? bte : 2'b00));
            check("we", 64'(wb_we), 64'(we));
            check("sel", 64'(wb_sel), 64'(sel));
            if (wb_stb) begin
                if (we) check("wb_dat", 64'(wb_dat_out), 64'(wd[k]));
                if (k == err_beat) begin
                    wb_err = 1'b1;
                    wb_ack = ($urandom_range(0, 1) != 0);
                    wb_rty = ($urandom_range(0, 1) != 0);
                end else if (k == rty_beat) begin
                    wb_rty = 1'b1;
                    wb_ack = ($urandom_range(0, 1) != 0);
                end else begin
                    wb_ack = ($urandom_range(0, 2) != 0);
                end
                wb_dat_in = slave_mem[wb_adr[9:2]];
            end
            #1;
            beat_ok = wb_stb && wb_ack && !wb_err && !wb_rty;
            term    = wb_stb && (wb_err || wb_rty || (wb_ack && k == n - 1));
            check("wdat_ready", 64'(wdat_ready), 64'(beat_ok && we));
            check("rsp_valid", 64'(rsp_valid), 64'(term));
            if (term) begin
                check("rsp_err", 64'(rsp_err), 64'(wb_err));
                check("rsp_rty", 64'(rsp_rty), 64'(!wb_err && wb_rty));
                check("rsp_beats", 64'(rsp_beats), 64'(k + (beat_ok ? 1 : 0)));
            end
            if (beat_ok && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel[b]) slave_mem[wb_adr[9:2]][8*b +: 8] = wb_dat_out[8*b +: 8];
                    if (sel[b]) ref_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
                end
            end
            if (beat_ok && !we) rexp = ref_mem[idx];
            @(posedge clk); #1;
            check("rdat_valid", 64'(rdat_valid), 64'(beat_ok && !we));
            if (beat_ok && !we) begin
                check("rdat", 64'(rdat), 64'(rexp));
                check("rdat_last", 64'(rdat_last), 64'(k == n - 1));
            end
            if (beat_ok) k++;
            done = term;
        end
        check("cmd_done_in_budget", 64'(done), 64'(1));
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wdat_valid = 1'b0;
        #1;
        check("cyc_drop", 64'(wb_cyc), 64'(0));
        check("stb_drop", 64'(wb_stb), 64'(0));
        ws = (wait_cfg > 8) ? 8 : wait_cfg;
        gap = 0;
        while (!cmd_ready && gap < 20) begin
            @(posedge clk); #1;
            gap++;
        end
        check("gap_cycles", 64'(gap), 64'(ws));
        $display("[TB] cmd adr=%08h we=%0d cti=%0d bte=%0d len=%0d wait=%0d beats=%0d", adr, we, cti, bte, len, wait_cfg, k);
    endtask

    initial begin
        logic [31:0] a;
        int n, eb, rb;
        rst_n = 1'b0; cfg_wait = '0; cmd_valid = 1'b0; cmd_adr = '0; cmd_we = 1'b0; cmd_sel = '0;
        cmd_cti = '0; cmd_bte = '0; cmd_len = '0; wdat_valid = 1'b0; wdat = '0; rdat_ready = 1'b0;
        wb_dat_in = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        check("reset_cyc", 64'(wb_cyc), 64'(0));
        check("reset_stb", 64'(wb_stb), 64'(0));
        check("reset_rsp", 64'(rsp_valid), 64'(0));
        check("reset_rdat_valid", 64'(rdat_valid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 64'(cmd_ready), 64'(1));

        // classic write then readback
        do_cmd(32'h100, 1'b1, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 2, -1, -1, -1, 32'hDEADBEEF);
        do_cmd(32'h100, 1'b0, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 0, -1, -1, -1, 32'h0);
        // linear incrementing write/read
        do_cmd(32'h000, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 4, 0, -1, -1, -1, 32'h1000);
        do_cmd(32'h000, 1'b0, 4'hF, CTI_INC_BURST, BTE_LINEAR, 4, 0, -1, -1, -1, 32'h0);
        // wrap4 read
        do_cmd(32'h018, 1'b0, 4'hF, CTI_INC_BURST, BTE_WRAP4, 4, 1, -1, -1, -1, 32'h0);
        // write stream stall after two beats
        do_cmd(32'h200, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 8, 0, -1, -1, 2, 32'h0);
        // error on beat 3, retry on beat 1
        do_cmd(32'h080, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 8, 1, 2, -1, -1, 32'h0);
        do_cmd(32'h080, 1'b0, 4'hF, CTI_INC_BURST, BTE_LINEAR, 4, 0, -1, 0, -1, 32'h0);
        // length 0/over-max clipping, wait saturation, const and len-1 burst
        do_cmd(32'h300, 1'b1, 4'h3, CTI_INC_BURST, BTE_LINEAR, 0, 12, -1, -1, -1, 32'h0);
        do_cmd(32'h040, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 40, 0, -1, -1, -1, 32'h0);
        do_cmd(32'h3F0, 1'b0, 4'hF, CTI_CONST_BURST, BTE_LINEAR, 3, 0, -1, -1, -1, 32'h0);

        // reset in the middle of a burst
        issue(32'h040, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 6'd8, 4'd0);
        wdat_valid = 1'b1; wb_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_cyc", 64'(wb_cyc), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_cyc", 64'(wb_cyc), 64'(0));
        check("midrst_stb", 64'(wb_stb), 64'(0));
        check("midrst_adr", 64'(wb_adr), 64'(0));
        check("midrst_we", 64'(wb_we), 64'(0));
        check("midrst_rsp", 64'(rsp_valid), 64'(0));
        check("midrst_ready", 64'(cmd_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; wdat_valid = 1'b0;
        @(posedge clk); #1;
        check("postrst_ready", 64'(cmd_ready), 64'(1));
        check("postrst_cyc", 64'(wb_cyc), 64'(0));
        $display("[TB] reset mid-burst done");

`ifdef WB_MASTER_TIMEOUT_EN
        begin
            int stalled = 0;
            bit seen = 0;
            issue(32'h020, 1'b1, 4'hF, CTI_INC_BURST, BTE_LINEAR, 6'd2, 4'd0);
            wdat_valid = 1'b1;
            for (int c = 0; c < 400 && !seen; c++) begin
                if (wb_stb) stalled++;
                if (rsp_valid) begin
                    seen = 1;
                    check("to_err", 64'(rsp_err), 64'(1));
                    check("to_beats", 64'(rsp_beats), 64'(0));
                end
                @(posedge clk); #1;
            end
            check("to_seen", 64'(seen), 64'(1));
            check("to_cycles", 64'(stalled), 64'(256));
            wdat_valid = 1'b0;
        end
`endif

        for (int t = 0; t < 40; t++) begin
            a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0;
            n = $urandom_range(1, 12);
            eb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
            rb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
            do_cmd(a, ($urandom_range(0, 1) != 0), 4'($urandom_range(1, 15)), 3'($urandom_range(0, 2)),
                   2'($urandom_range(0, 3)), n, $urandom_range(0, 10), eb, rb, -1, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
